// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package ccff_chain_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // MSBs of the first byte that fall outside the chain and are skipped
  function automatic int pad_bits(input int chain_len);
    return (8 - chain_len % 8) % 8;
  endfunction

  function automatic int bytes_per_load(input int chain_len);
    return (chain_len + 7) / 8;
  endfunction

endpackage

// File: rtl/ccff_chain_loader.sv
// Loads CHAIN_LEN config bits MSB-first onto ccff_head, one bit per cycle plus one LOAD bubble per byte.
// Input stalls freeze the shift; readback bytes are strobed one cycle after their last sample, no backpressure.
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 14,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic             i_prog_clk,
  input  logic             i_prog_reset_n,
  input  logic             i_start,
  input  logic [7:0]       i_s_data,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  output logic             o_ccff_head,
  output logic             o_ccff_shift_en,
  input  logic             i_ccff_tail,
  output logic [7:0]       o_rb_data,
  output logic             o_rb_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err_overrun,
  output logic [CNT_W-1:0] o_bit_count
);

  localparam int               PAD       = pad_bits(CHAIN_LEN);
  localparam logic [2:0]       FIRST_IDX = 3'(7 - PAD);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CHAIN_LEN - 1);

  state_e           r_state;
  logic [7:0]       r_byte;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_bit_count;
  logic             r_s_ready;
  logic             r_head;
  logic             r_shift_en;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [6:0]       r_rb_shift;
  logic [2:0]       r_rb_cnt;
  logic [7:0]       r_rb_data;
  logic             r_rb_valid;

  logic             w_accept;
  logic             w_last_bit;
  logic             w_start_ok;
  logic [2:0]       w_load_idx;
  logic [7:0]       w_rb_next;

  assign w_accept   = r_s_ready & i_s_valid;
  assign w_last_bit = (r_bit_count == LAST_CNT);
  assign w_start_ok = i_start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_load_idx = (r_bit_count == '0) ? FIRST_IDX : 3'd7;
  assign w_rb_next  = {r_rb_shift, i_ccff_tail};

  // head and shift_en are loaded one cycle ahead so both come straight from flops
  always_ff @(posedge i_prog_clk or negedge i_prog_reset_n) begin
    if (!i_prog_reset_n) begin
      r_state     <= ST_IDLE;
      r_byte      <= '0;
      r_idx       <= '0;
      r_bit_count <= '0;
      r_s_ready   <= 1'b0;
      r_head      <= 1'b0;
      r_shift_en  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state     <= ST_LOAD;
            r_s_ready   <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_bit_count <= '0;
          end else if ((r_state == ST_DONE) && i_s_valid) begin
            r_err <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_state    <= ST_SHIFT;
            r_byte     <= i_s_data;
            r_idx      <= w_load_idx;
            r_head     <= i_s_data[w_load_idx];
            r_shift_en <= 1'b1;
            r_s_ready  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_bit_count <= r_bit_count + 1'b1;
          if (w_last_bit) begin
            r_state    <= ST_DONE;
            r_shift_en <= 1'b0;
            r_head     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else if (r_idx == 3'd0) begin
            r_state    <= ST_LOAD;
            r_shift_en <= 1'b0;
            r_head     <= 1'b0;
            r_s_ready  <= 1'b1;
          end else begin
            r_idx  <= r_idx - 3'd1;
            r_head <= r_byte[r_idx - 3'd1];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A short final group is left-aligned so its first bit out still lands in the MSB
  always_ff @(posedge i_prog_clk or negedge i_prog_reset_n) begin
    if (!i_prog_reset_n) begin
      r_rb_shift <= '0;
      r_rb_cnt   <= '0;
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (r_shift_en) begin
        r_rb_shift <= w_rb_next[6:0];
        if (r_rb_cnt == 3'd7) begin
          r_rb_data  <= w_rb_next;
          r_rb_valid <= 1'b1;
          r_rb_cnt   <= '0;
        end else if (w_last_bit) begin
          r_rb_data  <= w_rb_next << (3'd7 - r_rb_cnt);
          r_rb_valid <= 1'b1;
          r_rb_cnt   <= '0;
        end else begin
          r_rb_cnt <= r_rb_cnt + 3'd1;
        end
      end else if (w_start_ok) begin
        r_rb_cnt <= '0;
      end
    end
  end

  assign o_s_ready       = r_s_ready;
  assign o_ccff_head     = r_head;
  assign o_ccff_shift_en = r_shift_en;
  assign o_rb_data       = r_rb_data;
  assign o_rb_valid      = r_rb_valid;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_err_overrun   = r_err;
  assign o_bit_count     = r_bit_count;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: directed scenarios plus random loads against a bit-list reference model.
module tb_ccff_chain_loader;
  import ccff_chain_loader_pkg::*;

  localparam int CHAIN_LEN = 14;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int PAD       = pad_bits(CHAIN_LEN);
  localparam int NB        = bytes_per_load(CHAIN_LEN);

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             start   = 1'b0;
  logic             s_valid = 1'b0;
  logic [7:0]       s_data  = 8'h00;
  logic             s_ready, head, shift_en, tail, rb_valid, busy, done, err;
  logic [7:0]       rb_data;
  logic [CNT_W-1:0] bit_count;

  int checks = 0;
  int errors = 0;

  // downstream chain model: tail is the MSB, head enters at bit 0
  logic [CHAIN_LEN-1:0] chain;
  logic [CHAIN_LEN-1:0] preload_val = '0;
  logic                 preload_req = 1'b0;
  bit                   head_q[$];
  logic [7:0]           rb_q[$];
  int                   shifts = 0;
  logic [7:0]           ld_bytes[NB];

  always #5 clk = ~clk;

  ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN)) u_dut (
    .i_prog_clk      (clk),
    .i_prog_reset_n  (rst_n),
    .i_start         (start),
    .i_s_data        (s_data),
    .i_s_valid       (s_valid),
    .o_s_ready       (s_ready),
    .o_ccff_head     (head),
    .o_ccff_shift_en (shift_en),
    .i_ccff_tail     (tail),
    .o_rb_data       (rb_data),
    .o_rb_valid      (rb_valid),
    .o_busy          (busy),
    .o_done          (done),
    .o_err_overrun   (err),
    .o_bit_count     (bit_count)
  );

  assign tail = chain[CHAIN_LEN-1];

  always @(posedge clk) begin
    if (preload_req) chain <= preload_val;
    else if (shift_en) chain <= {chain[CHAIN_LEN-2:0], head};
  end

  always @(negedge clk) begin
    if (shift_en) begin
      head_q.push_back(head);
      shifts++;
    end
    if (rb_valid) rb_q.push_back(rb_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("s_ready_wait", s_ready, 1);
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic do_load(input int stall, input bit poke);
    logic [CHAIN_LEN-1:0] old_img, exp_img, got_img;
    logic [CNT_W-1:0]     bc0;
    logic [7:0]           g, gg;
    bit                   bits[$];
    int                   hb, rb0, sb, n, k;
    old_img = chain;
    for (int i = 0; i < NB; i++)
      for (int j = 7; j >= 0; j--) bits.push_back(ld_bytes[i][j]);
    repeat (PAD) void'(bits.pop_front());
    for (int i = 0; i < CHAIN_LEN; i++) exp_img[CHAIN_LEN-1-i] = bits[i];
    hb  = head_q.size();
    rb0 = rb_q.size();
    sb  = shifts;

    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_ready", s_ready, 1);
    chk("start_done", done, 0);
    chk("start_err", err, 0);
    chk("start_cnt", bit_count, 0);

    for (int i = 0; i < NB; i++) begin
      if (i == 1 && stall > 0) begin
        n = 0;
        while (!s_ready && n < 50) begin
          @(negedge clk);
          n++;
        end
        repeat (stall) begin
          chk("stall_shen", shift_en, 0);
          chk("stall_cnt", bit_count, 8 - PAD);
          @(negedge clk);
        end
      end
      send_byte(ld_bytes[i]);
      if (i == 0 && poke) begin
        bc0 = bit_count;
        pulse_start();
        chk("poke_busy", busy, 1);
        chk("poke_mono", bit_count > bc0, 1);
      end
    end

    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done", done, 1);
    @(negedge clk);
    chk("shift_total", shifts - sb, CHAIN_LEN);
    chk("bit_count", bit_count, CHAIN_LEN);
    chk("busy_end", busy, 0);
    chk("head_n", head_q.size() - hb, CHAIN_LEN);
    got_img = '0;
    for (int i = 0; i < CHAIN_LEN; i++)
      if (hb + i < head_q.size()) got_img[CHAIN_LEN-1-i] = head_q[hb+i];
    chk("head_bits", got_img, exp_img);
    chk("chain_img", chain, exp_img);

    chk("rb_n", rb_q.size() - rb0, NB);
    for (int gi = 0; gi < NB; gi++) begin
      g = 8'h00;
      for (int j = 0; j < 8; j++) begin
        k = gi * 8 + j;
        if (k < CHAIN_LEN) g[7-j] = old_img[CHAIN_LEN-1-k];
      end
      gg = (rb0 + gi < rb_q.size()) ? rb_q[rb0+gi] : 8'hxx;
      chk("rb_data", gg, g);
    end
  endtask

  initial begin
    logic [CHAIN_LEN-1:0] img;
    int n, sb;

    preload_val = 14'b10110011100101;
    preload_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", {s_ready, head, shift_en, rb_valid, busy, done, err, rb_data, bit_count}, 0);
    preload_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    s_valid = 1'b1;
    s_data  = 8'hA5;
    @(negedge clk);
    chk("idle_ready", s_ready, 0);
    chk("idle_busy", {busy, shift_en, bit_count}, 0);
    s_valid = 1'b0;

    ld_bytes[0] = 8'hC3;
    ld_bytes[1] = 8'h5A;
    do_load(0, 0);
    chk("basic_chain", chain, 14'b00001101011010);
    chk("rb_first", (rb_q.size() >= 2) ? rb_q[rb_q.size()-2] : 8'h00, 8'hB3);
    chk("rb_second", (rb_q.size() >= 1) ? rb_q[rb_q.size()-1] : 8'h00, 8'h94);

    do_load(5, 0);
    chk("stall_chain", chain, 14'b00001101011010);

    img = chain;
    sb  = shifts;
    s_valid = 1'b1;
    s_data  = 8'hFF;
    chk("ovr_ready", s_ready, 0);
    @(negedge clk);
    s_valid = 1'b0;
    chk("ovr_err", err, 1);
    @(negedge clk);
    chk("ovr_sticky", err, 1);
    chk("ovr_done", done, 1);
    chk("ovr_chain", chain, img);
    chk("ovr_shifts", shifts - sb, 0);

    ld_bytes[0] = 8'($urandom);
    ld_bytes[1] = 8'($urandom);
    do_load(0, 1);

    ld_bytes[0] = 8'($urandom);
    pulse_start();
    send_byte(ld_bytes[0]);
    n = 0;
    while (bit_count != 5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_at5", bit_count, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {s_ready, head, shift_en, rb_valid, busy, done, err, rb_data, bit_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idle", {busy, s_ready, done, shift_en, bit_count}, 0);
    ld_bytes[0] = 8'($urandom);
    ld_bytes[1] = 8'($urandom);
    do_load(0, 0);

    for (int r = 0; r < 8; r++) begin
      ld_bytes[0] = 8'($urandom);
      ld_bytes[1] = 8'($urandom);
      do_load(int'($urandom_range(4, 0)), 1'($urandom_range(1, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
